// File: rtl/alarm_controller.sv
// Alarm sequencer: compares BCD time against the alarm, runs DISARMED/ARMED/RINGING/SNOOZING.
// Define ALARM_BUZZER_PATTERN_EN for a 0.5 s on / 0.5 s off buzzer; otherwise the buzzer is a steady tone.
module alarm_controller #(
    parameter int SNOOZE_MINUTES = 9,
    parameter int RING_TIMEOUT_S = 600,
    parameter int MAX_SNOOZES    = 3
) (
    input  logic        i_Clk_5MHz,
    input  logic        i_Reset,
    input  logic        i_Clk_100Hz_Pulse,
    input  logic [31:0] i_Time,
    input  logic        i_PM,
    input  logic [31:0] i_Alarm_Time,
    input  logic        i_Alarm_PM,
    input  logic        i_Alarm_Enable,
    input  logic        i_Snooze,
    input  logic        i_Dismiss,
    output logic        o_Ringing,
    output logic        o_Snoozing,
    output logic        o_Buzzer,
    output logic [3:0]  o_Snooze_Count
);

    typedef enum logic [1:0] {
        DISARMED,
        ARMED,
        RINGING,
        SNOOZING
    } state_e;

    localparam logic [19:0] SNOOZE_LOAD  = 20'(SNOOZE_MINUTES * 6000);
    localparam logic [19:0] RING_LOAD    = 20'(RING_TIMEOUT_S * 100);
    localparam logic [3:0]  SNOOZE_LIMIT = 4'(MAX_SNOOZES);

    state_e      state_q, state_d;
    logic [19:0] timer_q, timer_d;
    logic [3:0]  snooze_cnt_q, snooze_cnt_d;
    logic        match_q, match_d;
    logic        ringing_q, ringing_d;
    logic        snoozing_q, snoozing_d;
    logic        buzzer_q, buzzer_d;
    logic        trigger;
    logic        expire;
    logic        unused_alarm_low;

    // Seconds and hundredths of the alarm register are never compared.
    assign unused_alarm_low = ^i_Alarm_Time[15:0];

    assign match_d = (i_Time[31:16] == i_Alarm_Time[31:16]) &&
                     (i_PM == i_Alarm_PM) &&
                     (i_Time[15:0] == 16'h0000);
    assign trigger = match_d & ~match_q;
    assign expire  = i_Clk_100Hz_Pulse && (timer_q == 20'd1);

    always_ff @(posedge i_Clk_5MHz) begin
        if (!i_Reset) begin
            state_q <= DISARMED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!i_Alarm_Enable) begin
            state_d = DISARMED;
        end else begin
            case (state_q)
                DISARMED: state_d = ARMED;
                ARMED: begin
                    if (trigger) state_d = RINGING;
                end
                RINGING: begin
                    if (i_Dismiss)                                    state_d = ARMED;
                    else if (i_Snooze && (snooze_cnt_q < SNOOZE_LIMIT)) state_d = SNOOZING;
                    else if (expire)                                  state_d = ARMED;
                end
                SNOOZING: begin
                    if (i_Dismiss)   state_d = ARMED;
                    else if (expire) state_d = RINGING;
                end
                default: state_d = DISARMED;
            endcase
        end
    end

    // The shared timer is (re)loaded on every entry into a timed state, so a load beats a decrement.
    always_comb begin
        timer_d      = timer_q;
        snooze_cnt_d = snooze_cnt_q;
        if ((state_d == ARMED) || (state_d == DISARMED)) begin
            timer_d      = '0;
            snooze_cnt_d = '0;
        end else if ((state_d == SNOOZING) && (state_q != SNOOZING)) begin
            timer_d      = SNOOZE_LOAD;
            snooze_cnt_d = snooze_cnt_q + 4'd1;
        end else if ((state_d == RINGING) && (state_q != RINGING)) begin
            timer_d = RING_LOAD;
        end else if (i_Clk_100Hz_Pulse && (timer_q != '0)) begin
            timer_d = timer_q - 20'd1;
        end
    end

`ifdef ALARM_BUZZER_PATTERN_EN
    logic [5:0] pulse_cnt_q, pulse_cnt_d;
    logic       phase_q, phase_d;

    // Phase flips every 50 pulses of continuous ringing and restarts high on each entry.
    always_comb begin
        pulse_cnt_d = pulse_cnt_q;
        phase_d     = phase_q;
        if (state_d != RINGING) begin
            pulse_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (state_q != RINGING) begin
            pulse_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (i_Clk_100Hz_Pulse) begin
            if (pulse_cnt_q == 6'd49) begin
                pulse_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                pulse_cnt_d = pulse_cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge i_Clk_5MHz) begin
        if (!i_Reset) begin
            pulse_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            pulse_cnt_q <= pulse_cnt_d;
            phase_q     <= phase_d;
        end
    end
`endif

    always_comb begin
        ringing_d  = (state_d == RINGING);
        snoozing_d = (state_d == SNOOZING);
`ifdef ALARM_BUZZER_PATTERN_EN
        buzzer_d   = phase_d;
`else
        buzzer_d   = ringing_d;
`endif
    end

    always_ff @(posedge i_Clk_5MHz) begin
        if (!i_Reset) begin
            timer_q      <= '0;
            snooze_cnt_q <= '0;
            match_q      <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
            buzzer_q     <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            snooze_cnt_q <= snooze_cnt_d;
            match_q      <= match_d;
            ringing_q    <= ringing_d;
            snoozing_q   <= snoozing_d;
            buzzer_q     <= buzzer_d;
        end
    end

    assign o_Ringing      = ringing_q;
    assign o_Snoozing     = snoozing_q;
    assign o_Buzzer       = buzzer_q;
    assign o_Snooze_Count = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed scenarios plus randomized traffic
// checked against an event-level model of the alarm behaviour.
module tb_alarm_controller;

    localparam int SNOOZE_MIN = 1;
    localparam int RING_S     = 3;
    localparam int MAX_SN     = 3;
    localparam int SNOOZE_P   = SNOOZE_MIN * 6000;
    localparam int RING_P     = RING_S * 100;

    logic        clk = 1'b0;
    logic        rst_n, pulse, pm, alarm_pm, enable, snooze, dismiss;
    logic [31:0] time_bcd, alarm_time;
    logic        o_ring, o_snz, o_buz;
    logic [3:0]  o_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    bit m_prev, m_active, m_ring, m_snz;
    int m_left, m_snoozes, m_ring_pulses;

    always #100 clk = ~clk;

    alarm_controller #(
        .SNOOZE_MINUTES(SNOOZE_MIN),
        .RING_TIMEOUT_S(RING_S),
        .MAX_SNOOZES   (MAX_SN)
    ) dut (
        .i_Clk_5MHz       (clk),
        .i_Reset          (rst_n),
        .i_Clk_100Hz_Pulse(pulse),
        .i_Time           (time_bcd),
        .i_PM             (pm),
        .i_Alarm_Time     (alarm_time),
        .i_Alarm_PM       (alarm_pm),
        .i_Alarm_Enable   (enable),
        .i_Snooze         (snooze),
        .i_Dismiss        (dismiss),
        .o_Ringing        (o_ring),
        .o_Snoozing       (o_snz),
        .o_Buzzer         (o_buz),
        .o_Snooze_Count   (o_cnt)
    );

    // Event-level model: what the alarm should be doing after this clock edge.
    task automatic model_step();
        bit match, rise;
        match  = (time_bcd[31:16] == alarm_time[31:16]) && (pm == alarm_pm) && (time_bcd[15:0] == 16'h0);
        rise   = match && !m_prev;
        m_prev = match;
        if (!rst_n) begin
            m_prev = 0; m_active = 0; m_ring = 0; m_snz = 0;
            m_left = 0; m_snoozes = 0; m_ring_pulses = 0;
        end else if (!enable) begin
            m_active = 0; m_ring = 0; m_snz = 0; m_snoozes = 0;
        end else if (!m_active) begin
            m_active = 1;
        end else if (m_ring) begin
            if (dismiss) begin
                m_ring = 0; m_snoozes = 0;
            end else if (snooze && m_snoozes < MAX_SN) begin
                m_ring = 0; m_snz = 1; m_left = SNOOZE_P; m_snoozes++;
            end else if (pulse) begin
                m_left--; m_ring_pulses++;
                if (m_left == 0) begin
                    m_ring = 0; m_snoozes = 0;
                end
            end
        end else if (m_snz) begin
            if (dismiss) begin
                m_snz = 0; m_snoozes = 0;
            end else if (pulse) begin
                m_left--;
                if (m_left == 0) begin
                    m_snz = 0; m_ring = 1; m_left = RING_P; m_ring_pulses = 0;
                end
            end
        end else if (rise) begin
            m_ring = 1; m_left = RING_P; m_ring_pulses = 0;
        end
    endtask

    function automatic logic [6:0] expected();
        logic buz;
`ifdef ALARM_BUZZER_PATTERN_EN
        buz = m_ring && (((m_ring_pulses / 50) % 2) == 0);
`else
        buz = m_ring;
`endif
        return {m_ring, m_snz, buz, 4'(m_snoozes)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        snooze  = 1'b0;
        dismiss = 1'b0;
    endtask

    task automatic fire();
        time_bcd = 32'h0730_0001;
        tick();
        time_bcd = 32'h0730_0000;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pulse = 1'b0; pm = 1'b0; alarm_pm = 1'b0; enable = 1'b1;
        snooze = 1'b0; dismiss = 1'b0;
        time_bcd = 32'h1200_0000; alarm_time = 32'h0730_0000;
        tick();
        tick();
        n_cmp++;
        if ({o_ring, o_snz, o_buz, o_cnt} !== 7'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", {o_ring, o_snz, o_buz, o_cnt}, 7'b0);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({o_ring, o_snz, o_buz, o_cnt} !== expected()) begin
            n_fail++;
            $display("[TB] FAIL post_reset: got %b expected %b", {o_ring, o_snz, o_buz, o_cnt}, expected());
        end
    endtask

    task automatic test_trigger();
        time_bcd = 32'h0729_5900;
        tick();
        time_bcd = 32'h0730_0000;
        tick();
        n_cmp++;
        if (o_ring !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL trigger_ring: got %b expected 1", o_ring);
        end
        n_cmp++;
        if ({o_ring, o_snz, o_buz, o_cnt} !== expected()) begin
            n_fail++;
            $display("[TB] FAIL trigger_model: got %b expected %b", {o_ring, o_snz, o_buz, o_cnt}, expected());
        end
        dismiss = 1'b1;
        tick();
        for (int i = 0; i < 1000; i++) begin
            tick();
            n_cmp++;
            if (o_ring !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL no_retrigger[%0d]: got %b expected 0", i, o_ring);
            end
        end
    endtask

    task automatic test_snooze_limit();
        fire();
        for (int k = 1; k <= MAX_SN; k++) begin
            snooze = 1'b1;
            tick();
            n_cmp++;
            if ({o_snz, o_cnt} !== {1'b1, 4'(k)}) begin
                n_fail++;
                $display("[TB] FAIL snooze_enter[%0d]: got %b expected %b", k, {o_snz, o_cnt}, {1'b1, 4'(k)});
            end
            pulse = 1'b1;
            repeat (SNOOZE_P - 1) tick();
            n_cmp++;
            if ({o_ring, o_snz, o_buz, o_cnt} !== expected()) begin
                n_fail++;
                $display("[TB] FAIL snooze_before_expiry[%0d]: got %b expected %b", k, {o_ring, o_snz, o_buz, o_cnt}, expected());
            end
            tick();
            pulse = 1'b0;
            n_cmp++;
            if ({o_ring, o_cnt} !== {1'b1, 4'(k)}) begin
                n_fail++;
                $display("[TB] FAIL snooze_return[%0d]: got %b expected %b", k, {o_ring, o_cnt}, {1'b1, 4'(k)});
            end
        end
        snooze = 1'b1;
        tick();
        n_cmp++;
        if ({o_ring, o_snz, o_cnt} !== {2'b10, 4'(MAX_SN)}) begin
            n_fail++;
            $display("[TB] FAIL snooze_over_limit: got %b expected %b", {o_ring, o_snz, o_cnt}, {2'b10, 4'(MAX_SN)});
        end
        dismiss = 1'b1;
        tick();
        n_cmp++;
        if ({o_ring, o_snz, o_buz, o_cnt} !== expected()) begin
            n_fail++;
            $display("[TB] FAIL dismiss_after_limit: got %b expected %b", {o_ring, o_snz, o_buz, o_cnt}, expected());
        end
    endtask

    task automatic test_timeout();
        fire();
        pulse = 1'b1;
        for (int i = 0; i < RING_P; i++) begin
            tick();
            n_cmp++;
            if ({o_ring, o_snz, o_buz, o_cnt} !== expected()) begin
                n_fail++;
                $display("[TB] FAIL timeout_step[%0d]: got %b expected %b", i, {o_ring, o_snz, o_buz, o_cnt}, expected());
            end
            if (i == RING_P - 2) begin
                n_cmp++;
                if (o_ring !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL timeout_early: got %b expected 1", o_ring);
                end
            end
        end
        pulse = 1'b0;
        n_cmp++;
        if ({o_ring, o_cnt} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL timeout_end: got %b expected %b", {o_ring, o_cnt}, 5'b0);
        end
    endtask

    task automatic test_priority();
        fire();
        snooze = 1'b1; dismiss = 1'b1;
        tick();
        n_cmp++;
        if ({o_ring, o_snz, o_cnt} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL snooze_and_dismiss: got %b expected %b", {o_ring, o_snz, o_cnt}, 6'b0);
        end
        fire();
        dismiss = 1'b1; enable = 1'b0;
        tick();
        n_cmp++;
        if ({o_ring, o_snz, o_buz, o_cnt} !== 7'b0) begin
            n_fail++;
            $display("[TB] FAIL disable_and_dismiss: got %b expected %b", {o_ring, o_snz, o_buz, o_cnt}, 7'b0);
        end
        fire();
        n_cmp++;
        if (o_ring !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL disarmed_ignores_match: got %b expected 0", o_ring);
        end
        enable = 1'b1;
        tick();
        fire();
        n_cmp++;
        if ({o_ring, o_snz, o_buz, o_cnt} !== expected()) begin
            n_fail++;
            $display("[TB] FAIL rearm_ring: got %b expected %b", {o_ring, o_snz, o_buz, o_cnt}, expected());
        end
        dismiss = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_event();
        fire();
        snooze = 1'b1;
        tick();
        pulse = 1'b1;
        repeat (SNOOZE_P) tick();
        pulse = 1'b0;
        snooze = 1'b1;
        tick();
        n_cmp++;
        if ({o_snz, o_cnt} !== 5'b1_0010) begin
            n_fail++;
            $display("[TB] FAIL second_snooze: got %b expected %b", {o_snz, o_cnt}, 5'b1_0010);
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({o_ring, o_snz, o_buz, o_cnt} !== 7'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_event: got %b expected %b", {o_ring, o_snz, o_buz, o_cnt}, 7'b0);
        end
        time_bcd = 32'h0730_0001;
        rst_n = 1'b1;
        tick();
        tick();
        time_bcd = 32'h0730_0000;
        tick();
        n_cmp++;
        if ({o_ring, o_cnt} !== 5'b1_0000) begin
            n_fail++;
            $display("[TB] FAIL ring_after_reset: got %b expected %b", {o_ring, o_cnt}, 5'b1_0000);
        end
        dismiss = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 5000; i++) begin
            pulse   = ($urandom_range(0, 3) == 0);
            snooze  = ($urandom_range(0, 49) == 0);
            dismiss = ($urandom_range(0, 149) == 0);
            enable  = ($urandom_range(0, 299) != 0);
            rst_n   = ($urandom_range(0, 799) != 0);
            pm      = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: time_bcd = 32'h0730_0000;
                1: time_bcd = 32'h0730_0001;
                2: time_bcd = $urandom;
                default: ;
            endcase
            tick();
            n_cmp++;
            if ({o_ring, o_snz, o_buz, o_cnt} !== expected()) begin
                n_fail++;
                $display("[TB] FAIL random[%0d]: got %b expected %b", i, {o_ring, o_snz, o_buz, o_cnt}, expected());
            end
        end
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_snooze_limit();
        test_timeout();
        test_priority();
        test_reset_mid_event();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
